// File: rtl/anabellek_denetleyici.sv
// Main-memory responder: arbitrates fetch/data block requests and splits each
// 128-bit block transfer into four 32-bit beats on the word memory port.
module anabellek_denetleyici (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         getir_istek_i,
  input  logic [31:0]  getir_adres_i,
  input  logic         getir_oku_i,
  input  logic         getir_yaz_i,
  output logic         getir_veri_hazir_o,
  output logic [127:0] getir_okunan_obek_o,
  input  logic         bellek_istek_i,
  input  logic [31:0]  bellek_adres_i,
  input  logic         bellek_oku_i,
  input  logic         bellek_yaz_i,
  input  logic [127:0] bellek_yazilacak_obek_i,
  output logic         bellek_veri_hazir_o,
  output logic [127:0] bellek_okunan_obek_o,
  output logic         anabellek_musait_o,
  output logic         mem_istek_o,
  output logic         mem_yaz_o,
  output logic [31:0]  mem_adres_o,
  output logic [31:0]  mem_yaz_veri_o,
  input  logic         mem_hazir_i,
  input  logic [31:0]  mem_okunan_veri_i
);

  typedef enum logic [2:0] {
    BOSTA,
    GETIR_OKU,
    BELLEK_OKU,
    BELLEK_YAZ,
    CEVAP
  } durum_t;

  durum_t        durum;
  logic [1:0]    k;
  logic [31:0]   taban;
  logic [127:0]  yaz_obek;
  logic          kaynak_bellek;
  logic          son_bellek;

  logic          getir_gecerli;
  logic          bellek_gecerli;
  logic          bellek_sec;
  logic          aktarim;
  logic          unused_bits;

  assign unused_bits = ^{getir_yaz_i, getir_adres_i[3:0], bellek_adres_i[3:0]};

  assign getir_gecerli  = getir_istek_i & getir_oku_i;
  assign bellek_gecerli = bellek_istek_i & (bellek_oku_i | bellek_yaz_i);
  // Round-robin between two sources: the one not served last wins a tie.
  assign bellek_sec     = bellek_gecerli & (~getir_gecerli | ~son_bellek);

  assign aktarim = (durum == GETIR_OKU) | (durum == BELLEK_OKU) | (durum == BELLEK_YAZ);

  assign anabellek_musait_o = (durum == BOSTA);
  assign mem_istek_o        = aktarim;
  assign mem_yaz_o          = (durum == BELLEK_YAZ);
  assign mem_adres_o        = aktarim ? (taban + {28'd0, k, 2'b00}) : '0;

  always_comb begin
    mem_yaz_veri_o = '0;
    if (durum == BELLEK_YAZ) begin
      case (k)
        2'd0:    mem_yaz_veri_o = yaz_obek[31:0];
        2'd1:    mem_yaz_veri_o = yaz_obek[63:32];
        2'd2:    mem_yaz_veri_o = yaz_obek[95:64];
        default: mem_yaz_veri_o = yaz_obek[127:96];
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum                <= BOSTA;
      k                    <= '0;
      taban                <= '0;
      yaz_obek             <= '0;
      kaynak_bellek        <= 1'b0;
      son_bellek           <= 1'b0;
      getir_veri_hazir_o   <= 1'b0;
      bellek_veri_hazir_o  <= 1'b0;
      getir_okunan_obek_o  <= '0;
      bellek_okunan_obek_o <= '0;
    end else begin
      getir_veri_hazir_o  <= 1'b0;
      bellek_veri_hazir_o <= 1'b0;
      case (durum)
        BOSTA: begin
          k <= '0;
          if (bellek_sec) begin
            taban         <= {bellek_adres_i[31:4], 4'h0};
            kaynak_bellek <= 1'b1;
            yaz_obek      <= bellek_yazilacak_obek_i;
            durum         <= bellek_yaz_i ? BELLEK_YAZ : BELLEK_OKU;
          end else if (getir_gecerli) begin
            taban         <= {getir_adres_i[31:4], 4'h0};
            kaynak_bellek <= 1'b0;
            durum         <= GETIR_OKU;
          end
        end
        GETIR_OKU, BELLEK_OKU, BELLEK_YAZ: begin
          if (mem_hazir_i) begin
            if (durum == GETIR_OKU)
              getir_okunan_obek_o[{k, 5'd0} +: 32] <= mem_okunan_veri_i;
            if (durum == BELLEK_OKU)
              bellek_okunan_obek_o[{k, 5'd0} +: 32] <= mem_okunan_veri_i;
            k <= k + 2'd1;
            if (k == 2'd3) begin
              durum               <= CEVAP;
              getir_veri_hazir_o  <= ~kaynak_bellek;
              bellek_veri_hazir_o <= kaynak_bellek;
            end
          end
        end
        CEVAP: begin
          son_bellek <= kaynak_bellek;
          durum      <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Bench for anabellek_denetleyici: table of block transactions plus hand-written
// arbitration, ignored-request and reset-abort sequences, beats checked via a queue.
module tb_anabellek_denetleyici;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         getir_istek_i;
  logic [31:0]  getir_adres_i;
  logic         getir_oku_i;
  logic         getir_yaz_i;
  logic         getir_veri_hazir_o;
  logic [127:0] getir_okunan_obek_o;
  logic         bellek_istek_i;
  logic [31:0]  bellek_adres_i;
  logic         bellek_oku_i;
  logic         bellek_yaz_i;
  logic [127:0] bellek_yazilacak_obek_i;
  logic         bellek_veri_hazir_o;
  logic [127:0] bellek_okunan_obek_o;
  logic         anabellek_musait_o;
  logic         mem_istek_o;
  logic         mem_yaz_o;
  logic [31:0]  mem_adres_o;
  logic [31:0]  mem_yaz_veri_o;
  logic         mem_hazir_i;
  logic [31:0]  mem_okunan_veri_i;

  anabellek_denetleyici dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .getir_istek_i           (getir_istek_i),
    .getir_adres_i           (getir_adres_i),
    .getir_oku_i             (getir_oku_i),
    .getir_yaz_i             (getir_yaz_i),
    .getir_veri_hazir_o      (getir_veri_hazir_o),
    .getir_okunan_obek_o     (getir_okunan_obek_o),
    .bellek_istek_i          (bellek_istek_i),
    .bellek_adres_i          (bellek_adres_i),
    .bellek_oku_i            (bellek_oku_i),
    .bellek_yaz_i            (bellek_yaz_i),
    .bellek_yazilacak_obek_i (bellek_yazilacak_obek_i),
    .bellek_veri_hazir_o     (bellek_veri_hazir_o),
    .bellek_okunan_obek_o    (bellek_okunan_obek_o),
    .anabellek_musait_o      (anabellek_musait_o),
    .mem_istek_o             (mem_istek_o),
    .mem_yaz_o               (mem_yaz_o),
    .mem_adres_o             (mem_adres_o),
    .mem_yaz_veri_o          (mem_yaz_veri_o),
    .mem_hazir_i             (mem_hazir_i),
    .mem_okunan_veri_i       (mem_okunan_veri_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: the 0x1230 block holds 0x11..0x44, everything else is address-derived.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:4] == 28'h0000123)
      return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] b);
    return {mem_rd(b + 32'd12), mem_rd(b + 32'd8), mem_rd(b + 32'd4), mem_rd(b)};
  endfunction

  assign mem_okunan_veri_i = mem_rd(mem_adres_o);

  typedef struct {
    logic [31:0] adr;
    logic        yaz;
    logic [31:0] veri;
  } beat_t;

  typedef struct {
    logic         src;
    logic         rd;
    logic         wr;
    logic [31:0]  adr;
    logic [127:0] wblk;
    logic [127:0] eblk;
    int           stall_beat;
    int           stall_len;
    int           lat;
  } vec_t;

  beat_t        q[$];
  int           n_pass = 0;
  int           n_chk  = 0;
  logic [127:0] exp_g  = '0;
  logic [127:0] exp_b  = '0;

  task automatic chk(input string ad, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", ad, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && mem_istek_o && mem_hazir_i) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL beat_unexpected: got beat at %h expected none", mem_adres_o);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_addr", mem_adres_o, e.adr);
        chk("beat_write", mem_yaz_o, e.yaz);
        chk("beat_wdata", mem_yaz_veri_o, e.veri);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    getir_istek_i = 0; getir_oku_i = 0; getir_yaz_i = 0; getir_adres_i = '0;
    bellek_istek_i = 0; bellek_oku_i = 0; bellek_yaz_i = 0; bellek_adres_i = '0;
    bellek_yazilacak_obek_i = '0;
  endtask

  task automatic push_beats(input logic [31:0] base, input logic yaz, input logic [127:0] w);
    for (int unsigned i = 0; i < 4; i++)
      q.push_back('{base + 32'(4 * i), yaz, yaz ? w[32*i +: 32] : 32'd0});
  endtask

  task automatic run_vec(input vec_t v, input string ad);
    int t, beats, stalled;
    logic fire;
    logic [31:0] base;
    base = {v.adr[31:4], 4'h0};
    if (v.src) begin
      bellek_istek_i = 1; bellek_oku_i = v.rd; bellek_yaz_i = v.wr;
      bellek_adres_i = v.adr; bellek_yazilacak_obek_i = v.wblk;
    end else begin
      getir_istek_i = 1; getir_oku_i = v.rd; getir_yaz_i = v.wr; getir_adres_i = v.adr;
    end
    mem_hazir_i = 1;
    chk({ad, "_musait_idle"}, anabellek_musait_o, 1);
    push_beats(base, v.src & v.wr, v.wblk);
    tick();
    chk({ad, "_musait_busy"}, anabellek_musait_o, 0);
    // Changes after acceptance must not affect the transaction.
    getir_adres_i = ~v.adr; bellek_adres_i = ~v.adr; bellek_yazilacak_obek_i = ~v.wblk;
    t = 0; beats = 0; stalled = 0;
    while (t < 40) begin
      if (beats == v.stall_beat && stalled < v.stall_len) begin
        mem_hazir_i = 0; stalled++;
      end else mem_hazir_i = 1;
      if (!mem_hazir_i) chk({ad, "_stall_addr"}, mem_adres_o, base + 32'(4 * beats));
      fire = mem_istek_o & mem_hazir_i;
      tick();
      t++;
      if (fire) beats++;
      if (getir_veri_hazir_o | bellek_veri_hazir_o) break;
    end
    chk({ad, "_latency"}, t + 1, v.lat);
    chk({ad, "_pulse_sel"}, {getir_veri_hazir_o, bellek_veri_hazir_o}, v.src ? 2'b01 : 2'b10);
    if (v.src && !v.wr) exp_b = v.eblk;
    if (!v.src) exp_g = v.eblk;
    chk({ad, "_getir_blk"}, getir_okunan_obek_o, exp_g);
    chk({ad, "_bellek_blk"}, bellek_okunan_obek_o, exp_b);
    idle_inputs();
    mem_hazir_i = 1;
    tick();
    chk({ad, "_pulse_once"}, {getir_veri_hazir_o, bellek_veri_hazir_o}, 2'b00);
    chk({ad, "_musait_back"}, anabellek_musait_o, 1);
    chk({ad, "_queue_empty"}, q.size(), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int d0, d1, g0, nd, ng;
    vec_t v;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, '0,
               128'h00000044_00000033_00000022_00000011, -1, 0, 5};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0, -1, 0, 5};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_3008, '0, blk(32'h3000), -1, 0, 5};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, '0, blk(32'hFFFF_FFF0), -1, 0, 5};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_4000, '0, blk(32'h4000), 2, 3, 8};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_050C,
               128'h89ABCDEF_01234567_FEDCBA98_76543210, '0, 1, 1, 6};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_7777, '0, blk(32'h7770), -1, 0, 5};

    rst_i = 1; mem_hazir_i = 1;
    idle_inputs();
    tick(); tick();
    chk("rst_getir_blk", getir_okunan_obek_o, '0);
    chk("rst_bellek_blk", bellek_okunan_obek_o, '0);
    chk("rst_pulses", {getir_veri_hazir_o, bellek_veri_hazir_o}, 2'b00);
    chk("rst_mem_ctl", {mem_istek_o, mem_yaz_o}, 2'b00);
    chk("rst_mem_adr", mem_adres_o, '0);
    chk("rst_mem_wdata", mem_yaz_veri_o, '0);
    chk("rst_musait", anabellek_musait_o, 1);
    rst_i = 0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Invalid requests: fetch write-only and data request with neither oku nor yaz.
    getir_istek_i = 1; getir_oku_i = 0; getir_yaz_i = 1; getir_adres_i = 32'h100;
    bellek_istek_i = 1; bellek_oku_i = 0; bellek_yaz_i = 0; bellek_adres_i = 32'h200;
    tick(); tick(); tick();
    chk("ignored_musait", anabellek_musait_o, 1);
    chk("ignored_no_beat", mem_istek_o, 0);
    idle_inputs();

    // Arbitration: both held continuously after reset -> data, fetch, data.
    rst_i = 1; tick(); rst_i = 0; exp_g = '0; exp_b = '0;
    getir_istek_i = 1; getir_oku_i = 1; getir_adres_i = 32'h2000;
    bellek_istek_i = 1; bellek_oku_i = 1; bellek_adres_i = 32'h3000;
    push_beats(32'h3000, 0, '0);
    push_beats(32'h2000, 0, '0);
    push_beats(32'h3000, 0, '0);
    tick();
    d0 = -1; d1 = -1; g0 = -1; nd = 0; ng = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (bellek_veri_hazir_o) begin
        if (nd == 0) d0 = n + 1; else d1 = n + 1;
        nd++;
      end
      if (getir_veri_hazir_o) begin
        if (ng == 0) g0 = n + 1;
        ng++;
      end
    end
    idle_inputs();
    tick();
    chk("arb_data_count", nd, 2);
    chk("arb_fetch_count", ng, 1);
    chk("arb_data_first", d0, 5);
    chk("arb_fetch_cycle", g0, 11);
    chk("arb_data_second", d1, 17);
    chk("arb_queue_empty", q.size(), 0);
    chk("arb_getir_blk", getir_okunan_obek_o, blk(32'h2000));
    chk("arb_bellek_blk", bellek_okunan_obek_o, blk(32'h3000));
    exp_g = blk(32'h2000); exp_b = blk(32'h3000);

    // Reset abort in cycle 2 of a fetch read.
    getir_istek_i = 1; getir_oku_i = 1; getir_adres_i = 32'h6000;
    push_beats(32'h6000, 0, '0);
    tick();
    tick();
    chk("abort_partial", getir_okunan_obek_o[31:0], mem_rd(32'h6000));
    rst_i = 1;
    #1;
    q.delete();
    chk("abort_getir_blk", getir_okunan_obek_o, '0);
    chk("abort_bellek_blk", bellek_okunan_obek_o, '0);
    chk("abort_outputs", {getir_veri_hazir_o, bellek_veri_hazir_o, mem_istek_o, mem_yaz_o,
                          mem_adres_o, mem_yaz_veri_o}, '0);
    idle_inputs();
    tick();
    chk("abort_no_pulse", {getir_veri_hazir_o, bellek_veri_hazir_o}, 2'b00);
    rst_i = 0;
    exp_g = '0; exp_b = '0;
    v = '{1'b0, 1'b1, 1'b0, 32'h0000_6000, '0, blk(32'h6000), -1, 0, 5};
    run_vec(v, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
